tier2_ram_arb: RTL and testbench
================================

// Module: tier2_ram_arb
// PURPOSE
//  Parametrised successor to the tier-2 single-port RAM wrapper. Arbitrates independent write and read
//  requesters onto one single-port array with req/ack handshakes, a bounded-starvation read guarantee
//  and a configurable read pipeline. Adds out-of-range detection and a hardware clear sweep.
//  Sits between the tier-2 packet builder (writer) and the codestream output stage (reader).
// PARAMETERS
//  ADDR_WIDTH   14     address width, bits
//  WORD_WIDTH   18     data word width, bits
//  DEPTH        12288  implemented words; valid addresses are 0..DEPTH-1 (DEPTH <= 2**ADDR_WIDTH)
//  RD_LATENCY   1      cycles from read grant to rd_valid; legal values 1 or 2 (2 adds an output register)
//  STARVE_MAX   4      max consecutive write grants while a read is pending; legal range 1..15
// PORTS
//  rd_clk       in   1           single clock; all logic on the rising edge
//  rst_n        in   1           asynchronous active-low reset
//  wr_req       in   1           write request; held with wr_addr/wr_data until wr_ack
//  wr_addr      in   ADDR_WIDTH  write address
//  wr_data      in   WORD_WIDTH  write data
//  wr_ack       out  1           combinational; write granted this cycle
//  rd_req       in   1           read request; held with rd_addr until rd_ack
//  rd_addr      in   ADDR_WIDTH  read address
//  rd_ack       out  1           combinational; read granted this cycle
//  rd_data      out  WORD_WIDTH  read data; valid only while rd_valid=1
//  rd_valid     out  1           one-cycle pulse per granted read
//  rd_err       out  1           pulses with rd_valid when the read address was >= DEPTH
//  clr_start    in   1           single-cycle pulse; starts the zero-fill sweep
//  clr_busy     out  1           high while the sweep runs
// BEHAVIOUR
//  - Reset: wr_ack, rd_ack, rd_valid, rd_err and clr_busy = 0; rd_data = 0; starvation counter = 0;
//    read pipeline flushed; any sweep aborted. Array contents are NOT reset.
//  - One array access per cycle. Write and read are never granted in the same cycle.
//  - Arbitration in a given cycle (clr_busy=0):
//    write only -> wr_ack; read only -> rd_ack.
//    both -> wr_ack, unless starve_cnt == STARVE_MAX, then rd_ack.
//  - starve_cnt: +1 on each write grant while rd_req=1; cleared on rd_ack or whenever rd_req=0;
//    saturates at STARVE_MAX.
//  - Write: on wr_ack with wr_addr < DEPTH, mem[wr_addr] <= wr_data at that edge. With wr_addr >= DEPTH,
//    the write is acked and dropped (no array update).
//  - Read: a grant in cycle t gives rd_valid=1 in cycle t+RD_LATENCY.
//    rd_data = mem[rd_addr] (0 and rd_err=1 if rd_addr >= DEPTH).
//    rd_data holds its last value while rd_valid=0.
//  - Ordering: an access sees all earlier-granted writes. A write acked in cycle t followed by a read
//    of the same address acked in t+1 returns the new data. Back-to-back reads give back-to-back rd_valid.
//  - Clear FSM, states IDLE -> SWEEP -> IDLE:
//    clr_start in IDLE -> SWEEP next cycle, clr_busy=1, ptr=0.
//    In SWEEP, mem[ptr] <= 0 and ptr += 1 every cycle; after ptr = DEPTH-1 -> IDLE, clr_busy=0.
//    The sweep lasts exactly DEPTH cycles.
//    In SWEEP, wr_ack=rd_ack=0; requests stay pending and starve_cnt holds.
//    Reads granted before SWEEP still complete with pre-clear data.
//    clr_start during SWEEP is ignored. clr_start and requests in the same IDLE cycle: the request is
//    granted that cycle and the sweep starts next cycle.
//  - Requester protocol violations (dropping req or changing addr/data before ack) are undefined.
//    The RTL does not need to detect them.
// TESTING
//  1 reset: assert rst_n=0 mid-traffic -> all outputs 0 asynchronously; after release, wr 5->0x2A5A5 then
//    rd 5 -> rd_data=0x2A5A5 with rd_valid at ack+RD_LATENCY.
//  2 contention: wr_req and rd_req held high, STARVE_MAX=4 -> exactly 4 wr_acks then 1 rd_ack,
//    pattern repeating; no cycle with both acks.
//  3 RAW/latency: wr addr 100=0x155 in cycle t, rd addr 100 in t+1, for RD_LATENCY=1 and 2 ->
//    0x155 at t+2 and t+3 respectively.
//  4 range: wr addr 12288 (DEPTH=12288), then rd 12288 -> rd_valid=1, rd_err=1, rd_data=0.
//    rd 0 is unchanged by the out-of-range write.
//  5 clear: fill the array, pulse clr_start, hold rd_req -> clr_busy high 12288 cycles and no acks;
//    second clr_start ignored; afterwards all sampled addresses read 0.
//  6 reset during SWEEP at ptr=50 -> clr_busy=0 immediately; after release, acks resume at once.

Source files
------------

// File: rtl/tier2_ram_arb.sv
// Tier-2 single-port RAM with write/read arbitration, bounded read starvation,
// out-of-range detection, a 1- or 2-cycle read pipeline and a zero-fill sweep.
module tier2_ram_arb #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned WORD_WIDTH = 18,
    parameter int unsigned DEPTH      = 12288,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WORD_WIDTH-1:0] wr_data,
    output logic                  wr_ack,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ack,
    output logic [WORD_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_err,
    input  logic                  clr_start,
    output logic                  clr_busy
);

    typedef enum logic [0:0] {StIdle, StSweep} clr_state_e;

    localparam int unsigned CntWidth = 4;
    localparam logic [ADDR_WIDTH-1:0] LastAddr  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CntWidth-1:0]   StarveMax = CntWidth'(STARVE_MAX);

    logic [WORD_WIDTH-1:0] mem [DEPTH];

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [CntWidth-1:0]   starve_q, starve_d;
    logic                  wr_in_range, rd_in_range;

    logic                  s1_valid, s1_err;
    logic [WORD_WIDTH-1:0] s1_data;

    assign clr_busy    = (state_q == StSweep);
    assign wr_in_range = 32'(wr_addr) < DEPTH;
    assign rd_in_range = 32'(rd_addr) < DEPTH;

    // Acks are gated by rst_n so they drop the moment reset asserts.
    always_comb begin
        wr_ack = 1'b0;
        rd_ack = 1'b0;
        if (rst_n && !clr_busy) begin
            if (wr_req && rd_req) begin
                if (starve_q == StarveMax) begin
                    rd_ack = 1'b1;
                end else begin
                    wr_ack = 1'b1;
                end
            end else begin
                wr_ack = wr_req;
                rd_ack = rd_req;
            end
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!clr_busy) begin
            if (rd_ack || !rd_req) begin
                starve_d = '0;
            end else if (wr_ack && (starve_q != StarveMax)) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (clr_start) begin
                    state_d = StSweep;
                    ptr_d   = '0;
                end
            end
            StSweep: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LastAddr) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            starve_q <= starve_d;
        end
    end

    // Array is deliberately not reset; out-of-range writes are acked but dropped.
    always_ff @(posedge rd_clk) begin
        if (clr_busy) begin
            mem[ptr_q] <= '0;
        end else if (wr_ack && wr_in_range) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_ack;
            s1_err   <= rd_ack && !rd_in_range;
            if (rd_ack) begin
                s1_data <= rd_in_range ? mem[rd_addr] : '0;
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_out_reg
        logic                  valid_q, err_q;
        logic [WORD_WIDTH-1:0] data_q;

        always_ff @(posedge rd_clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                err_q   <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= s1_valid;
                err_q   <= s1_err;
                if (s1_valid) begin
                    data_q <= s1_data;
                end
            end
        end

        assign rd_valid = valid_q;
        assign rd_err   = err_q;
        assign rd_data  = data_q;
    end else begin : g_no_out_reg
        assign rd_valid = s1_valid;
        assign rd_err   = s1_err;
        assign rd_data  = s1_data;
    end

endmodule

// File: tb/tb_tier2_ram_arb.sv
// Bench for tier2_ram_arb: RD_LATENCY=1 and RD_LATENCY=2 instances share stimulus and are
// checked every cycle against a behavioural model, plus directed literal checks.
module tb_tier2_ram_arb;

    localparam int AW    = 14;
    localparam int WW    = 18;
    localparam int DEPTH = 12288;
    localparam int SMAX  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_req, rd_req, clr_start;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [WW-1:0] wr_data;

    logic [1:0]    wr_ack_o, rd_ack_o, rd_valid_o, rd_err_o, clr_busy_o;
    logic [WW-1:0] rd_data_o [2];

    always #5 clk = ~clk;

    tier2_ram_arb #(
        .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .DEPTH(DEPTH), .RD_LATENCY(1), .STARVE_MAX(SMAX)
    ) u_l1 (
        .rd_clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack_o[0]),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack_o[0]),
        .rd_data(rd_data_o[0]), .rd_valid(rd_valid_o[0]), .rd_err(rd_err_o[0]),
        .clr_start(clr_start), .clr_busy(clr_busy_o[0])
    );

    tier2_ram_arb #(
        .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .DEPTH(DEPTH), .RD_LATENCY(2), .STARVE_MAX(SMAX)
    ) u_l2 (
        .rd_clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack_o[1]),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack_o[1]),
        .rd_data(rd_data_o[1]), .rd_valid(rd_valid_o[1]), .rd_err(rd_err_o[1]),
        .clr_start(clr_start), .clr_busy(clr_busy_o[1])
    );

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // Model state: array image, grant history (entry k = read granted k+1 cycles ago),
    // consecutive writes while a read waits, remaining sweep cycles.
    typedef struct packed {
        logic          v;
        logic          e;
        logic [WW-1:0] d;
    } grant_t;

    logic [WW-1:0] mm [DEPTH];
    grant_t        hist [2];
    logic [WW-1:0] exp_data [2];
    int            consec, sweep_left;
    bit            exp_wr_ack, exp_rd_ack;

    logic          s_wr_ack, s_rd_ack, s_busy;
    logic [1:0]    s_valid, s_err;
    logic [WW-1:0] s_data [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic model_reset();
        hist[0]     = '0;
        hist[1]     = '0;
        exp_data[0] = '0;
        exp_data[1] = '0;
        consec      = 0;
        sweep_left  = 0;
        exp_wr_ack  = 1'b0;
        exp_rd_ack  = 1'b0;
    endtask

    // Compare at the falling edge, advance the model to the next rising edge.
    task automatic cycle();
        bit     ew, er, eb;
        grant_t g;
        @(negedge clk);
        eb = (sweep_left > 0);
        ew = 1'b0;
        er = 1'b0;
        if (!eb) begin
            if (wr_req && rd_req) begin
                if (consec == SMAX) er = 1'b1;
                else ew = 1'b1;
            end else begin
                ew = wr_req;
                er = rd_req;
            end
        end
        for (int l = 0; l < 2; l++) begin
            if (hist[l].v) exp_data[l] = hist[l].d;
            chk($sformatf("wr_ack[L%0d]", l + 1), 32'(wr_ack_o[l]), 32'(ew));
            chk($sformatf("rd_ack[L%0d]", l + 1), 32'(rd_ack_o[l]), 32'(er));
            chk($sformatf("clr_busy[L%0d]", l + 1), 32'(clr_busy_o[l]), 32'(eb));
            chk($sformatf("rd_valid[L%0d]", l + 1), 32'(rd_valid_o[l]), 32'(hist[l].v));
            chk($sformatf("rd_err[L%0d]", l + 1), 32'(rd_err_o[l]), 32'(hist[l].v & hist[l].e));
            chk($sformatf("rd_data[L%0d]", l + 1), 32'(rd_data_o[l]), 32'(exp_data[l]));
            s_valid[l] = rd_valid_o[l];
            s_err[l]   = rd_err_o[l];
            s_data[l]  = rd_data_o[l];
        end
        s_wr_ack = wr_ack_o[0];
        s_rd_ack = rd_ack_o[0];
        s_busy   = clr_busy_o[0];

        g.v = er;
        g.e = (int'(rd_addr) >= DEPTH);
        g.d = (int'(rd_addr) < DEPTH) ? mm[rd_addr] : '0;
        hist[1] = hist[0];
        hist[0] = g;
        if (ew && int'(wr_addr) < DEPTH) mm[wr_addr] = wr_data;
        if (!eb) begin
            if (er || !rd_req) consec = 0;
            else if (ew && consec < SMAX) consec++;
        end
        if (eb) begin
            mm[DEPTH - sweep_left] = '0;
            sweep_left--;
        end else if (clr_start) begin
            sweep_left = DEPTH;
        end
        exp_wr_ack = ew;
        exp_rd_ack = er;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] pick_addr();
        int r = $urandom_range(0, 99);
        if (r < 60) return AW'($urandom_range(0, 15));
        else if (r < 70) return AW'($urandom_range(DEPTH, DEPTH + 40));
        else return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    task automatic rand_step();
        if (!wr_req || exp_wr_ack) begin
            wr_req  = ($urandom_range(0, 99) < 60);
            wr_addr = pick_addr();
            wr_data = WW'($urandom);
        end
        if (!rd_req || exp_rd_ack) begin
            rd_req  = ($urandom_range(0, 99) < 50);
            rd_addr = pick_addr();
        end
        cycle();
    endtask

    // Assert reset between edges with both requests high; everything must drop at once.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        for (int l = 0; l < 2; l++) begin
            chk({tag, "_wr_ack"}, 32'(wr_ack_o[l]), 32'd0);
            chk({tag, "_rd_ack"}, 32'(rd_ack_o[l]), 32'd0);
            chk({tag, "_rd_valid"}, 32'(rd_valid_o[l]), 32'd0);
            chk({tag, "_rd_err"}, 32'(rd_err_o[l]), 32'd0);
            chk({tag, "_clr_busy"}, 32'(clr_busy_o[l]), 32'd0);
            chk({tag, "_rd_data"}, 32'(rd_data_o[l]), 32'd0);
        end
        model_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic read_expect(input string tag, input logic [AW-1:0] a, input logic [WW-1:0] d,
                               input logic e);
        rd_req  = 1'b1;
        rd_addr = a;
        cycle();
        chk({tag, "_ack"}, 32'(s_rd_ack), 32'd1);
        rd_req = 1'b0;
        cycle();
        chk({tag, "_v1"}, 32'(s_valid[0]), 32'd1);
        chk({tag, "_d1"}, 32'(s_data[0]), 32'(d));
        chk({tag, "_e1"}, 32'(s_err[0]), 32'(e));
        cycle();
        chk({tag, "_v2"}, 32'(s_valid[1]), 32'd1);
        chk({tag, "_d2"}, 32'(s_data[1]), 32'(d));
        chk({tag, "_e2"}, 32'(s_err[1]), 32'(e));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt, ack_cnt;
        logic [AW-1:0] probe [5];
        rst_n     = 1'b0;
        wr_req    = 1'b0;
        rd_req    = 1'b0;
        clr_start = 1'b0;
        wr_addr   = '0;
        rd_addr   = '0;
        wr_data   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(clr_busy_o[0]), 32'd0);
        chk("rst_data", 32'(rd_data_o[1]), 32'd0);
        rst_n = 1'b1;

        // Clear once so the array image is known.
        clr_start = 1'b1;
        cycle();
        clr_start = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) cycle();

        for (int i = 0; i < 600; i++) rand_step();

        // Reset mid-traffic, then a write/read of address 5.
        wr_req = 1'b1;
        rd_req = 1'b1;
        async_reset("rst1");
        wr_req  = 1'b1;
        wr_addr = AW'(5);
        wr_data = WW'('h2A5A5);
        rd_req  = 1'b0;
        cycle();
        chk("rst1_wr5_ack", 32'(s_wr_ack), 32'd1);
        wr_req = 1'b0;
        read_expect("rst1_rd5", AW'(5), WW'('h2A5A5), 1'b0);

        // Contention: 4 writes then 1 read, repeating.
        wr_req  = 1'b1;
        wr_addr = AW'(8);
        wr_data = WW'('h3);
        rd_req  = 1'b1;
        rd_addr = AW'(8);
        for (int i = 0; i < 15; i++) begin
            cycle();
            chk("cont_wr", 32'(s_wr_ack), 32'(i % 5 != 4));
            chk("cont_rd", 32'(s_rd_ack), 32'(i % 5 == 4));
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        repeat (3) cycle();

        // Read-after-write on consecutive cycles.
        wr_req  = 1'b1;
        wr_addr = AW'(100);
        wr_data = WW'('h155);
        cycle();
        wr_req = 1'b0;
        read_expect("raw100", AW'(100), WW'('h155), 1'b0);

        // Out-of-range write is dropped; back-to-back reads give back-to-back valids.
        wr_req  = 1'b1;
        wr_addr = AW'(0);
        wr_data = WW'('h1234);
        cycle();
        wr_addr = AW'(DEPTH);
        wr_data = WW'('h3FFFF);
        cycle();
        wr_req  = 1'b0;
        rd_req  = 1'b1;
        rd_addr = AW'(DEPTH);
        cycle();
        rd_addr = AW'(0);
        cycle();
        rd_req = 1'b0;
        chk("oor_v1", 32'(s_valid[0]), 32'd1);
        chk("oor_e1", 32'(s_err[0]), 32'd1);
        chk("oor_d1", 32'(s_data[0]), 32'd0);
        cycle();
        chk("rd0_v1", 32'(s_valid[0]), 32'd1);
        chk("rd0_e1", 32'(s_err[0]), 32'd0);
        chk("rd0_d1", 32'(s_data[0]), 32'h1234);
        chk("oor_e2", 32'(s_err[1]), 32'd1);
        cycle();
        chk("rd0_d2", 32'(s_data[1]), 32'h1234);
        cycle();

        for (int i = 0; i < 600; i++) rand_step();
        wr_req = 1'b0;
        rd_req = 1'b0;
        repeat (3) cycle();

        // Fill, then clear with requests held and a second clr_start mid-sweep.
        for (int i = 0; i < DEPTH; i++) begin
            wr_req  = 1'b1;
            wr_addr = AW'(i);
            wr_data = WW'(i * 7 + 3);
            cycle();
        end
        wr_addr   = AW'(3);
        wr_data   = WW'('h111);
        rd_req    = 1'b1;
        rd_addr   = AW'(9);
        clr_start = 1'b1;
        cycle();
        chk("clr_same_cycle_wr", 32'(s_wr_ack), 32'd1);
        busy_cnt = 0;
        ack_cnt  = 0;
        for (int i = 0; i < DEPTH + 8; i++) begin
            clr_start = (i == 100);
            cycle();
            if (s_busy) begin
                busy_cnt++;
                if (s_wr_ack || s_rd_ack) ack_cnt++;
            end
        end
        clr_start = 1'b0;
        chk("clr_len", 32'(busy_cnt), 32'(DEPTH));
        chk("clr_acks", 32'(ack_cnt), 32'd0);
        wr_req = 1'b0;
        rd_req = 1'b0;
        repeat (3) cycle();
        probe[0] = AW'(0);
        probe[1] = AW'(1);
        probe[2] = AW'(4000);
        probe[3] = AW'(DEPTH - 1);
        probe[4] = AW'($urandom_range(10, DEPTH - 2));
        for (int i = 0; i < 5; i++) read_expect("clr_rd", probe[i], '0, 1'b0);

        // Reset during sweep at ptr=50.
        clr_start = 1'b1;
        cycle();
        clr_start = 1'b0;
        for (int i = 0; i < 50; i++) cycle();
        chk("sweep_busy_pre", 32'(s_busy), 32'd1);
        async_reset("rst2");
        wr_req  = 1'b1;
        wr_addr = AW'(7);
        wr_data = WW'('h2F0F);
        rd_req  = 1'b1;
        rd_addr = AW'(7);
        cycle();
        chk("rst2_wr_ack", 32'(s_wr_ack), 32'd1);
        chk("rst2_rd_ack", 32'(s_rd_ack), 32'd0);
        wr_req = 1'b0;
        for (int i = 0; i < 400; i++) rand_step();
        wr_req = 1'b0;
        rd_req = 1'b0;
        repeat (3) cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
